mem_arb_ctrl: RTL and testbench

- Arbitrates one fixed-latency unified memory port between the fetch-side requester (I-cache miss path, read-only) and the data-side requester (D-cache miss/writeback path).
- Sits between the pipeline/caches and the memory model.
- Sequences each access through issue, wait and completion, and returns read data with a one-cycle done pulse.
- Data side has priority, with a bounded-streak anti-starvation rule for fetch. Saturating grant counters feed the bench's cache-request statistics.

---
 rtl/mem_arb_ctrl_pkg.sv | 20 ++
 rtl/mem_arb_ctrl_sat_cnt16.sv | 31 +++
 rtl/mem_arb_ctrl.sv | 157 +++++++++++++++
 tb/tb_mem_arb_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_ctrl_pkg.sv
// Shared definitions for the unified memory arbiter: FSM encodings,
// owner codes, counter width and the saturating increment helper.
package mem_arb_ctrl_pkg;

    localparam int CNT_W = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arb_ctrl_sat_cnt16.sv
// 16-bit saturating event counter with synchronous active-low clear.
module sat_cnt16
    import mem_arb_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             clr_ni,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise saturating increment when enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (!clr_ni) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arb_ctrl.sv
// Arbiter between fetch (read-only) and data requesters for a single
// fixed-latency memory port. Data side has priority; fetch is forced after
// MAX_STREAK consecutive data grants taken while fetch was waiting.
module mem_arb_ctrl
    import mem_arb_ctrl_pkg::*;
#(
    parameter int MEM_LAT    = 4,
    parameter int MAX_STREAK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [15:0]      i_addr,
    output logic             i_done,
    output logic [15:0]      i_rdata,
    input  logic             d_req,
    input  logic             d_wr,
    input  logic [15:0]      d_addr,
    input  logic [15:0]      d_wdata,
    output logic             d_done,
    output logic [15:0]      d_rdata,
    output logic             mem_en,
    output logic             mem_wr,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    input  logic [15:0]      mem_rdata,
    output logic             busy,
    output logic [CNT_W-1:0] i_grant_cnt,
    output logic [CNT_W-1:0] d_grant_cnt
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);
    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);

    logic [1:0]  state_q,   state_d;
    logic        owner_q,   owner_d;
    logic        wr_q,      wr_d;
    logic [15:0] addr_q,    addr_d;
    logic [15:0] wdata_q,   wdata_d;
    logic [3:0]  streak_q,  streak_d;
    logic [3:0]  lat_q,     lat_d;
    logic [15:0] i_rdata_q, i_rdata_d;
    logic [15:0] d_rdata_q, d_rdata_d;

    logic idle;
    logic grant_d;
    logic grant_i;

    // Arbitration is only acted upon in IDLE; fetch wins a tie once the
    // data streak has reached its limit.
    assign idle    = (state_q == ST_IDLE);
    assign grant_d = d_req && !(i_req && (streak_q == STREAK_MAX));
    assign grant_i = !grant_d && i_req;

    // FSM next state, request latching, streak tracking and read capture.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        streak_d  = streak_q;
        lat_d     = lat_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_d) begin
                    owner_d  = OWNER_D;
                    wr_d     = d_wr;
                    addr_d   = d_addr;
                    wdata_d  = d_wdata;
                    streak_d = i_req ? streak_q + 4'd1 : 4'd0;
                    state_d  = ST_ISSUE;
                end else if (grant_i) begin
                    owner_d  = OWNER_I;
                    wr_d     = 1'b0;
                    addr_d   = i_addr;
                    wdata_d  = '0;
                    streak_d = 4'd0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                lat_d   = LAT_INIT;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_q == 4'd0) begin
                    if (!wr_q) begin
                        if (owner_q == OWNER_D) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            i_rdata_d = mem_rdata;
                        end
                    end
                    state_d = ST_DONE;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWNER_I;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            streak_q  <= '0;
            lat_q     <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            streak_q  <= streak_d;
            lat_q     <= lat_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    sat_cnt16 u_i_cnt (
        .clk_i  (clk),
        .clr_ni (rst),
        .en_i   (idle && grant_i),
        .cnt_o  (i_grant_cnt)
    );

    sat_cnt16 u_d_cnt (
        .clk_i  (clk),
        .clr_ni (rst),
        .en_i   (idle && grant_d),
        .cnt_o  (d_grant_cnt)
    );

    assign mem_en    = (state_q == ST_ISSUE);
    assign mem_wr    = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = !idle;
    assign i_done    = (state_q == ST_DONE) && (owner_q == OWNER_I);
    assign d_done    = (state_q == ST_DONE) && (owner_q == OWNER_D);
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed bench for mem_arb_ctrl: default build (MEM_LAT=4, MAX_STREAK=2),
// a MEM_LAT=1 build, and a standalone saturating counter.
module tb_mem_arb_ctrl;
    import mem_arb_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_done, d_done, mem_en, mem_wr, busy;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, i_grant_cnt, d_grant_cnt;

    logic        l1_i_req;
    logic [15:0] l1_i_addr, l1_mem_rdata;
    logic        l1_i_done, l1_d_done, l1_mem_en, l1_mem_wr, l1_busy;
    logic [15:0] l1_i_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata, l1_i_cnt, l1_d_cnt;

    logic        sat_clr_n, sat_en;
    logic [15:0] sat_cnt;

    int n_cmp = 0;
    int n_err = 0;

    mem_arb_ctrl #(.MEM_LAT(4), .MAX_STREAK(2)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy),
        .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
    );

    mem_arb_ctrl #(.MEM_LAT(1), .MAX_STREAK(2)) dut1 (
        .clk(clk), .rst(rst),
        .i_req(l1_i_req), .i_addr(l1_i_addr), .i_done(l1_i_done), .i_rdata(l1_i_rdata),
        .d_req(1'b0), .d_wr(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
        .d_done(l1_d_done), .d_rdata(l1_d_rdata),
        .mem_en(l1_mem_en), .mem_wr(l1_mem_wr), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
        .mem_rdata(l1_mem_rdata), .busy(l1_busy),
        .i_grant_cnt(l1_i_cnt), .d_grant_cnt(l1_d_cnt)
    );

    sat_cnt16 u_sat (
        .clk_i(clk), .clr_ni(sat_clr_n), .en_i(sat_en), .cnt_o(sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete access on the MEM_LAT=4 instance, starting from an IDLE cycle.
    task automatic access(input string tag, input logic is_d, input logic wr,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] rdata);
        if (is_d) begin
            d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        step();                                       // cycle 1
        chk1 ({tag, "_en_c1"},   mem_en, 1'b1);
        chk16({tag, "_addr_c1"}, mem_addr, addr);
        chk1 ({tag, "_wr_c1"},   mem_wr, wr);
        if (wr) chk16({tag, "_wdata_c1"}, mem_wdata, wdata);
        step();                                       // cycle 2
        chk1 ({tag, "_en_c2"},   mem_en, 1'b0);
        chk16({tag, "_addr_c2"}, mem_addr, addr);
        step(); step(); step();                       // cycle 5
        mem_rdata = rdata;
        chk1 ({tag, "_done_c5"}, is_d ? d_done : i_done, 1'b0);
        step();                                       // cycle 6
        mem_rdata = 16'hDEAD;
        chk1 ({tag, "_done_c6"}, is_d ? d_done : i_done, 1'b1);
        chk1 ({tag, "_other_c6"}, is_d ? i_done : d_done, 1'b0);
        if (!wr) chk16({tag, "_rdata"}, is_d ? d_rdata : i_rdata, rdata);
        if (is_d) d_req = 1'b0; else i_req = 1'b0;
        step();                                       // back in IDLE
        chk1 ({tag, "_busy_end"}, busy, 1'b0);
    endtask

    logic [15:0] order [6];
    logic        saw_done;

    initial begin
        rst = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = 16'hDEAD;
        l1_i_req = 1'b0; l1_i_addr = '0; l1_mem_rdata = 16'hDEAD;
        sat_clr_n = 1'b0; sat_en = 1'b0;
        step(); step();

        // Reset state
        chk1 ("rst_busy",   busy, 1'b0);
        chk1 ("rst_mem_en", mem_en, 1'b0);
        chk1 ("rst_i_done", i_done, 1'b0);
        chk1 ("rst_d_done", d_done, 1'b0);
        chk16("rst_addr",   mem_addr, 16'h0000);
        chk16("rst_icnt",   i_grant_cnt, 16'h0000);
        chk16("rst_dcnt",   d_grant_cnt, 16'h0000);
        rst = 1'b1;
        step();

        // I-only read, then D write, D read, D write
        access("iread",  1'b0, 1'b0, 16'h0040, 16'h0000, 16'hC0DE);
        chk16("iread_icnt", i_grant_cnt, 16'd1);
        chk16("iread_dcnt", d_grant_cnt, 16'd0);
        access("dwr1",   1'b1, 1'b1, 16'h0100, 16'hBEEF, 16'h1234);
        chk16("dwr1_rdata_kept", d_rdata, 16'h0000);
        access("drd",    1'b1, 1'b0, 16'h0200, 16'h0000, 16'h5A5A);
        access("dwr2",   1'b1, 1'b1, 16'h0300, 16'h0F0F, 16'h9999);
        chk16("dwr2_rdata_kept", d_rdata, 16'h5A5A);
        chk16("dwr2_irdata_kept", i_rdata, 16'hC0DE);
        chk16("dwr2_dcnt", d_grant_cnt, 16'd3);

        // Both requesters held continuously: D, D, I, D, D, I
        order[0] = 16'h2222; order[1] = 16'h2222; order[2] = 16'h1111;
        order[3] = 16'h2222; order[4] = 16'h2222; order[5] = 16'h1111;
        i_req = 1'b1; i_addr = 16'h1111;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h2222;
        for (int k = 0; k < 6; k++) begin
            step();
            chk1 ($sformatf("arb%0d_en", k), mem_en, 1'b1);
            chk16($sformatf("arb%0d_addr", k), mem_addr, order[k]);
            step(); step(); step(); step(); step();
            chk1 ($sformatf("arb%0d_ddone", k), d_done, order[k] == 16'h2222);
            chk1 ($sformatf("arb%0d_idone", k), i_done, order[k] == 16'h1111);
            if (k == 5) begin
                i_req = 1'b0; d_req = 1'b0;
            end
            step();
        end
        chk16("arb_icnt", i_grant_cnt, 16'd3);
        chk16("arb_dcnt", d_grant_cnt, 16'd7);

        // Reset in cycle 3 of a D read
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0400;
        step(); step(); step();                       // cycle 3
        rst = 1'b0;
        step();
        d_req = 1'b0;
        chk1 ("mrst_busy",   busy, 1'b0);
        chk1 ("mrst_mem_en", mem_en, 1'b0);
        chk16("mrst_icnt",   i_grant_cnt, 16'h0000);
        chk16("mrst_dcnt",   d_grant_cnt, 16'h0000);
        rst = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mem_rdata = 16'h7777;
            step();
            saw_done = saw_done | d_done | i_done | busy;
        end
        mem_rdata = 16'hDEAD;
        chk1 ("mrst_no_done", saw_done, 1'b0);
        chk16("mrst_drdata",  d_rdata, 16'h0000);
        access("post_rst", 1'b0, 1'b0, 16'h0080, 16'h0000, 16'h1357);
        chk16("post_rst_icnt", i_grant_cnt, 16'd1);
        chk16("post_rst_dcnt", d_grant_cnt, 16'd0);

        // MEM_LAT=1 build: mem_en cycle 1, capture cycle 2, done cycle 3
        l1_i_req = 1'b1; l1_i_addr = 16'h0033;
        step();
        chk1 ("l1_en_c1",   l1_mem_en, 1'b1);
        chk16("l1_addr_c1", l1_mem_addr, 16'h0033);
        step();
        l1_mem_rdata = 16'h2468;
        chk1 ("l1_en_c2",   l1_mem_en, 1'b0);
        chk1 ("l1_done_c2", l1_i_done, 1'b0);
        step();
        l1_mem_rdata = 16'hDEAD;
        chk1 ("l1_done_c3", l1_i_done, 1'b1);
        chk16("l1_rdata",   l1_i_rdata, 16'h2468);
        chk16("l1_icnt",    l1_i_cnt, 16'd1);
        l1_i_req = 1'b0;
        step();
        chk1 ("l1_busy_end", l1_busy, 1'b0);

        // Saturating counter: reach 0xFFFF and stay there
        sat_clr_n = 1'b1; sat_en = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk16("sat_fffe", sat_cnt, 16'hFFFE);
        step();
        chk16("sat_ffff", sat_cnt, 16'hFFFF);
        step(); step();
        chk16("sat_hold", sat_cnt, 16'hFFFF);
        sat_en = 1'b0; sat_clr_n = 1'b0;
        step();
        chk16("sat_clr", sat_cnt, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
